// File: rtl/buffer_fill_pkg.sv
// Shared types and defaults for the buffer fill scheduler.
// Holds the FSM state encoding, default sizes and an index-width helper.
package buffer_fill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_TIMEOUT = 15;

    // Bits needed to index n items, never less than one.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/buffer_fill_scheduler_if.sv
// Buffer-side and scratchpad-side signals of the fill scheduler.
// master is the scheduler; slave is the buffer/scratchpad environment.
interface buffer_fill_scheduler_if
    import buffer_fill_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic               start;
    logic [NUM_REQ-1:0] req;
    logic               buf_valid;
    logic [DATA_W-1:0]  buf_data;
    logic               buf_read_req;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               busy;
    logic               err;

    modport master (
        input  start, req, buf_valid, buf_data,
        output buf_read_req, grant, wr_en, wr_addr, wr_data, busy, err
    );

    modport slave (
        output start, req, buf_valid, buf_data,
        input  buf_read_req, grant, wr_en, wr_addr, wr_data, busy, err
    );

endinterface

// File: rtl/buffer_fill_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i.
// Returns the winner both one-hot and as an index.
module rr_arbiter
    import buffer_fill_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    int               cand_n;
    logic [IDX_W-1:0] cand;

    // Scan requesters starting at the rotation pointer, wrapping once.
    always_comb begin
        gnt_o  = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        cand_n = 0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_n = int'(ptr_i) + k;
            if (cand_n >= NUM_REQ) begin
                cand_n = cand_n - NUM_REQ;
            end
            cand = IDX_W'(cand_n);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/buffer_fill_scheduler.sv
// Round-robin scheduler sharing one buffer read port among scratchpad fills.
// Optional READ timeout with sticky err when SCHED_TIMEOUT_EN is defined.
module buffer_fill_scheduler
    import buffer_fill_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic clk,
    input logic rst,
    input logic inner_rst,
    buffer_fill_scheduler_if.master bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int IDX_W  = idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || DEPTH < 2 || TIMEOUT < 1) begin : g_bad_param
        $error("buffer_fill_scheduler: parameter out of range");
    end

    state_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [DATA_W-1:0]  wr_data_q;
    logic               rd_req_q;
    logic               busy_q;
    logic [IDX_W-1:0]   win_idx_q;
    logic [IDX_W-1:0]   rr_q;
    logic [ADDR_W-1:0]  ptr_q [NUM_REQ];

    logic [ADDR_W-1:0]  cur_ptr;
    logic [ADDR_W-1:0]  ptr_d;
    logic [IDX_W-1:0]   rr_d;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

`ifdef SCHED_TIMEOUT_EN
    localparam int CNT_W = idx_w(TIMEOUT);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i (bus.req),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign cur_ptr = ptr_q[win_idx_q];
    assign ptr_d   = (cur_ptr == ADDR_W'(DEPTH - 1)) ? '0 : cur_ptr + ADDR_W'(1);
    assign rr_d    = (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + IDX_W'(1);

    // Transfer FSM: grant in IDLE, wait for buffer data in READ, strobe in WRITE.
    always_ff @(posedge clk) begin
        if (!rst || inner_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            win_idx_q <= '0;
            rr_q      <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                ptr_q[i] <= '0;
            end
`ifdef SCHED_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && arb_any) begin
                        grant_q   <= arb_gnt;
                        win_idx_q <= arb_idx;
                        rd_req_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= READ;
`ifdef SCHED_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                    end
                end
                READ: begin
                    if (bus.buf_valid) begin
                        wr_data_q <= bus.buf_data;
                        wr_en_q   <= grant_q;
                        wr_addr_q <= cur_ptr;
                        rd_req_q  <= 1'b0;
                        state_q   <= WRITE;
                    end
`ifdef SCHED_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // Give up on this word; the pointer stays put.
                        grant_q  <= '0;
                        rd_req_q <= 1'b0;
                        busy_q   <= 1'b0;
                        rr_q     <= rr_d;
                        err_q    <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                WRITE: begin
                    ptr_q[win_idx_q] <= ptr_d;
                    rr_q      <= rr_d;
                    wr_en_q   <= '0;
                    wr_addr_q <= '0;
                    grant_q   <= '0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.buf_read_req = rd_req_q;
    assign bus.grant        = grant_q;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.busy         = busy_q;
`ifdef SCHED_TIMEOUT_EN
    assign bus.err          = err_q;
`else
    assign bus.err          = 1'b0;
`endif

endmodule
